// File: rtl/mem_line_serializer.sv
// Transmit side of the external memory data interface: buffers cache lines and sends each as two
// beats, upper half first. Define MEM_LINE_SERIALIZER_PARITY_EN to add the o_mem_parity output.
module mem_line_serializer #(
  parameter int unsigned EXT_MEM_DATA_WIDTH = 40,
  parameter int unsigned INT_MEM_DATA_WIDTH = 80,
  parameter int unsigned FIFO_DEPTH         = 2
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [INT_MEM_DATA_WIDTH-1:0] i_line,
  input  logic                          i_line_valid,
  output logic                          o_line_ready,
  input  logic                          i_ready,
  output logic [EXT_MEM_DATA_WIDTH-1:0] o_mem_data,
  output logic                          o_mem_data_valid,
  output logic                          o_beat_last,
  output logic                          o_busy
`ifdef MEM_LINE_SERIALIZER_PARITY_EN
  ,
  output logic                          o_mem_parity
`endif
);

  localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PtrW  = AddrW + 1;

  typedef enum logic [1:0] {StIdle, StHi, StLo} state_e;

  state_e                          r_state;
  logic [INT_MEM_DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]                 r_wr_ptr;
  logic [PtrW-1:0]                 r_rd_ptr;
  logic                            r_line_ready;
  logic [EXT_MEM_DATA_WIDTH-1:0]   r_line_lo;
  logic [EXT_MEM_DATA_WIDTH-1:0]   r_mem_data;
  logic                            r_mem_data_valid;
  logic                            r_beat_last;
  logic                            r_busy;

  logic                            w_empty;
  logic                            w_push;
  logic                            w_pop;
  logic [PtrW-1:0]                 w_wr_ptr_nxt;
  logic [PtrW-1:0]                 w_rd_ptr_nxt;
  logic                            w_empty_nxt;
  logic                            w_full_nxt;
  logic                            w_busy_nxt;
  logic [INT_MEM_DATA_WIDTH-1:0]   w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = i_line_valid & r_line_ready;
  // Pop whenever the FSM is about to start a fresh line: from idle, or back-to-back out of LO.
  assign w_pop   = ~w_empty & ((r_state == StIdle) | ((r_state == StLo) & i_ready));
  assign w_head  = r_mem[r_rd_ptr[AddrW-1:0]];

  assign w_wr_ptr_nxt = r_wr_ptr + {{AddrW{1'b0}}, w_push};
  assign w_rd_ptr_nxt = r_rd_ptr + {{AddrW{1'b0}}, w_pop};
  assign w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);
  assign w_full_nxt   = (w_wr_ptr_nxt[PtrW-1] != w_rd_ptr_nxt[PtrW-1]) &&
                        (w_wr_ptr_nxt[AddrW-1:0] == w_rd_ptr_nxt[AddrW-1:0]);
  // Next FSM state is non-idle unless LO completes with nothing left to pop.
  assign w_busy_nxt   = ~w_empty_nxt | w_pop | (r_state == StHi) |
                        ((r_state == StLo) & ~i_ready);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AddrW-1:0]] <= i_line;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_line_ready <= 1'b0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_line_ready <= ~w_full_nxt;
    end
  end

`ifdef MEM_LINE_SERIALIZER_PARITY_EN
  logic r_parity;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state          <= StIdle;
      r_line_lo        <= '0;
      r_mem_data       <= '0;
      r_mem_data_valid <= 1'b0;
      r_beat_last      <= 1'b0;
      r_busy           <= 1'b0;
`ifdef MEM_LINE_SERIALIZER_PARITY_EN
      r_parity         <= 1'b0;
`endif
    end else begin
      r_busy <= w_busy_nxt;
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_line_lo        <= w_head[EXT_MEM_DATA_WIDTH-1:0];
            r_mem_data       <= w_head[INT_MEM_DATA_WIDTH-1:EXT_MEM_DATA_WIDTH];
            r_mem_data_valid <= 1'b1;
            r_beat_last      <= 1'b0;
            r_state          <= StHi;
`ifdef MEM_LINE_SERIALIZER_PARITY_EN
            r_parity         <= ^w_head[INT_MEM_DATA_WIDTH-1:EXT_MEM_DATA_WIDTH];
`endif
          end
        end
        StHi: begin
          if (i_ready) begin
            r_mem_data  <= r_line_lo;
            r_beat_last <= 1'b1;
            r_state     <= StLo;
`ifdef MEM_LINE_SERIALIZER_PARITY_EN
            r_parity    <= ^r_line_lo;
`endif
          end
        end
        StLo: begin
          if (w_pop) begin
            r_line_lo        <= w_head[EXT_MEM_DATA_WIDTH-1:0];
            r_mem_data       <= w_head[INT_MEM_DATA_WIDTH-1:EXT_MEM_DATA_WIDTH];
            r_mem_data_valid <= 1'b1;
            r_beat_last      <= 1'b0;
            r_state          <= StHi;
`ifdef MEM_LINE_SERIALIZER_PARITY_EN
            r_parity         <= ^w_head[INT_MEM_DATA_WIDTH-1:EXT_MEM_DATA_WIDTH];
`endif
          end else if (i_ready) begin
            r_mem_data       <= '0;
            r_mem_data_valid <= 1'b0;
            r_beat_last      <= 1'b0;
            r_state          <= StIdle;
`ifdef MEM_LINE_SERIALIZER_PARITY_EN
            r_parity         <= 1'b0;
`endif
          end
        end
        default: begin
          r_mem_data_valid <= 1'b0;
          r_beat_last      <= 1'b0;
          r_state          <= StIdle;
        end
      endcase
    end
  end

  assign o_line_ready     = r_line_ready;
  assign o_mem_data       = r_mem_data;
  assign o_mem_data_valid = r_mem_data_valid;
  assign o_beat_last      = r_beat_last;
  assign o_busy           = r_busy;
`ifdef MEM_LINE_SERIALIZER_PARITY_EN
  assign o_mem_parity     = r_parity;
`endif

endmodule
